// File: rtl/accumulator_scheduler.sv
// accumulator_scheduler: sole master of the double-buffered accumulator memory.
// Round-robin arbitration of two writers (W0 systolic writeback, W1 host load) and
// two readers (R0 VPU, R1 host readback). Buffer CLEAR and SWAP commands are sequenced
// so that no data access overlaps a clear or uses a stale buffer select.
// Optional statistics counters are compiled in when ACC_SCHED_STATS_EN is defined.
module accumulator_scheduler #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w0_valid,
    output logic              w0_ready,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_valid,
    output logic              w1_ready,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              rd_rsp_valid,
    output logic              rd_rsp_id,
    output logic [DATA_W-1:0] rd_rsp_data,
    input  logic              clr_valid,
    output logic              clr_ready,
    input  logic              swp_valid,
    output logic              swp_ready,
    output logic              sched_idle,
    output logic              acc_buf_sel,
    output logic              acc_clear,
    input  logic              acc_clear_busy,
    input  logic              acc_clear_complete,
    output logic              acc_wr_en,
    output logic [ADDR_W-1:0] acc_wr_addr,
    output logic [DATA_W-1:0] acc_wr_data,
    output logic              acc_rd_en,
    output logic [ADDR_W-1:0] acc_rd_addr,
    input  logic [DATA_W-1:0] acc_rd_data
`ifdef ACC_SCHED_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [31:0]       stat_wr_stall,
    output logic [31:0]       stat_clr_cycles,
    output logic [15:0]       stat_swaps
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR_RUN,
        S_CLR_REL,
        S_SWP_SETTLE
    } state_t;

    state_t state_q, state_d;
    logic   buf_sel_q, buf_sel_d;
    logic   wr_prio_q, wr_prio_d;
    logic   rd_prio_q, rd_prio_d;
    logic   rsp_valid_q, rsp_id_q;
    logic   data_ok;
    logic   wr_ok;

    // State, buffer select, arbiter pointers and read-response tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            buf_sel_q   <= 1'b0;
            wr_prio_q   <= 1'b0;
            rd_prio_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_sel_q   <= buf_sel_d;
            wr_prio_q   <= wr_prio_d;
            rd_prio_q   <= rd_prio_d;
            rsp_valid_q <= acc_rd_en;
            rsp_id_q    <= r1_ready;
        end
    end

    // Command sequencing: clear beats swap, and either one blocks data grants that cycle
    always_comb begin
        state_d   = state_q;
        buf_sel_d = buf_sel_q;
        clr_ready = 1'b0;
        swp_ready = 1'b0;
        acc_clear = 1'b0;
        data_ok   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_valid) begin
                    clr_ready = 1'b1;
                    state_d   = S_CLR_RUN;
                end else if (swp_valid) begin
                    swp_ready = 1'b1;
                    buf_sel_d = ~buf_sel_q;
                    state_d   = S_SWP_SETTLE;
                end else begin
                    data_ok = 1'b1;
                end
            end
            S_CLR_RUN: begin
                acc_clear = 1'b1;
                if (acc_clear_complete) begin
                    state_d = S_CLR_REL;
                end
            end
            S_CLR_REL:    state_d = S_IDLE;
            S_SWP_SETTLE: state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Writes are additionally held off while the accumulator reports a clear in flight
    assign wr_ok    = data_ok && !acc_clear_busy;
    assign w0_ready = wr_ok && w0_valid && (!w1_valid || !wr_prio_q);
    assign w1_ready = wr_ok && w1_valid && (!w0_valid || wr_prio_q);
    assign r0_ready = data_ok && r0_valid && (!r1_valid || !rd_prio_q);
    assign r1_ready = data_ok && r1_valid && (!r0_valid || rd_prio_q);

    // Round-robin pointers: after a grant the other requester wins the next contention
    always_comb begin
        wr_prio_d = wr_prio_q;
        rd_prio_d = rd_prio_q;
        if (w0_ready) begin
            wr_prio_d = 1'b1;
        end else if (w1_ready) begin
            wr_prio_d = 1'b0;
        end
        if (r0_ready) begin
            rd_prio_d = 1'b1;
        end else if (r1_ready) begin
            rd_prio_d = 1'b0;
        end
    end

    assign acc_wr_en    = w0_ready || w1_ready;
    assign acc_wr_addr  = w1_ready ? w1_addr : (w0_ready ? w0_addr : '0);
    assign acc_wr_data  = w1_ready ? w1_data : (w0_ready ? w0_data : '0);
    assign acc_rd_en    = r0_ready || r1_ready;
    assign acc_rd_addr  = r1_ready ? r1_addr : (r0_ready ? r0_addr : '0);
    assign acc_buf_sel  = buf_sel_q;
    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_id    = rsp_id_q;
    assign rd_rsp_data  = acc_rd_data;
    assign sched_idle   = (state_q == S_IDLE) && !rsp_valid_q;

    // A write must never land while the accumulator is clearing
    a_no_wr_during_clear: assert property (@(posedge clk) disable iff (!rst_n)
        !(acc_wr_en && acc_clear_busy));

    // The buffer select is frozen for the whole clear sequence
    a_sel_stable_in_clear: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == S_CLR_RUN) || (state_q == S_CLR_REL)) |-> (buf_sel_d == buf_sel_q));

`ifdef ACC_SCHED_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] clr_cnt_q;
    logic [15:0] swp_cnt_q;
    logic        stall_evt;
    logic        clr_evt;
    logic        swp_evt;

    assign stall_evt = (w0_valid && !w0_ready) || (w1_valid && !w1_ready);
    assign clr_evt   = (state_q == S_CLR_RUN) || (state_q == S_CLR_REL);
    assign swp_evt   = swp_valid && swp_ready;

    // Saturating event counters, zeroed by a stat_clr pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            clr_cnt_q   <= '0;
            swp_cnt_q   <= '0;
        end else if (stat_clr) begin
            stall_cnt_q <= '0;
            clr_cnt_q   <= '0;
            swp_cnt_q   <= '0;
        end else begin
            if (stall_evt && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (clr_evt && (clr_cnt_q != '1)) begin
                clr_cnt_q <= clr_cnt_q + 32'd1;
            end
            if (swp_evt && (swp_cnt_q != '1)) begin
                swp_cnt_q <= swp_cnt_q + 16'd1;
            end
        end
    end

    assign stat_wr_stall   = stall_cnt_q;
    assign stat_clr_cycles = clr_cnt_q;
    assign stat_swaps      = swp_cnt_q;
`endif

endmodule

// File: tb/tb_accumulator_scheduler.sv
// Self-checking bench for accumulator_scheduler: an accumulator memory model with a
// 256-cycle clear sequencer, plus a reference scoreboard of both buffers and the
// round-robin grant rules, driven by directed command scenarios and random data traffic.
module tb_accumulator_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        w0_valid, w0_ready, w1_valid, w1_ready;
   logic [7:0]  w0_addr, w1_addr;
   logic [63:0] w0_data, w1_data;
   logic        r0_valid, r0_ready, r1_valid, r1_ready;
   logic [7:0]  r0_addr, r1_addr;
   logic        rd_rsp_valid, rd_rsp_id;
   logic [63:0] rd_rsp_data;
   logic        clr_valid, clr_ready, swp_valid, swp_ready;
   logic        sched_idle, acc_buf_sel, acc_clear;
   logic        acc_clear_busy, acc_clear_complete;
   logic        acc_wr_en, acc_rd_en;
   logic [7:0]  acc_wr_addr, acc_rd_addr;
   logic [63:0] acc_wr_data, acc_rd_data;

   int total = 0;
   int bad   = 0;

   // Reference state: expected buffer contents, selected buffer, last winners, pending response
   logic [63:0] sb [2][256];
   logic        bufSel;
   logic        lastW, lastR;
   logic        rspPend, rspId;
   logic [63:0] rspData;
   logic        gotW0, gotW1, gotR0, gotR1;

   // Accumulator model state
   logic [63:0] mem [2][256];
   logic        envBusy, envDone;
   logic [7:0]  envCnt;

   accumulator_scheduler #(.ADDR_W(8), .DATA_W(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr), .w0_data(w0_data),
      .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr), .w1_data(w1_data),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_id(rd_rsp_id), .rd_rsp_data(rd_rsp_data),
      .clr_valid(clr_valid), .clr_ready(clr_ready),
      .swp_valid(swp_valid), .swp_ready(swp_ready),
      .sched_idle(sched_idle), .acc_buf_sel(acc_buf_sel), .acc_clear(acc_clear),
      .acc_clear_busy(acc_clear_busy), .acc_clear_complete(acc_clear_complete),
      .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data),
      .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data)
   );

   always #5 clk = ~clk;

   assign acc_clear_busy     = envBusy;
   assign acc_clear_complete = envDone;

   // Accumulator model: registered reads, writes, and a clear that wipes one entry per cycle
   // (entry 0 on the start cycle, then 1..255), then holds done until the request drops
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         envBusy     <= 1'b0;
         envDone     <= 1'b0;
         envCnt      <= 8'd0;
         acc_rd_data <= 64'd0;
      end else begin
         if (acc_wr_en) mem[acc_buf_sel][acc_wr_addr] <= acc_wr_data;
         if (acc_rd_en) acc_rd_data <= mem[acc_buf_sel][acc_rd_addr];
         if (!acc_clear) envDone <= 1'b0;
         if (acc_clear && !envBusy && !envDone) begin
            mem[acc_buf_sel][0] <= 64'd0;
            envCnt  <= 8'd1;
            envBusy <= 1'b1;
         end else if (envBusy) begin
            mem[acc_buf_sel][envCnt] <= 64'd0;
            envCnt <= envCnt + 8'd1;
            if (envCnt == 8'd255) begin
               envBusy <= 1'b0;
               envDone <= 1'b1;
            end
         end
      end
   end

   // Hard stop in case the scheduler locks up somewhere unbounded
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One IDLE-state data cycle: check last cycle's read response, then this cycle's grants
   task automatic applyStimulus();
      logic eW0, eW1, eR0, eR1;
      #1;
      checkOutput("rsp_valid", rd_rsp_valid, rspPend);
      if (rspPend) begin
         checkOutput("rsp_id", rd_rsp_id, rspId);
         checkOutput("rsp_data", rd_rsp_data, rspData);
      end
      eW0 = w0_valid && (!w1_valid || lastW);
      eW1 = w1_valid && !eW0;
      eR0 = r0_valid && (!r1_valid || lastR);
      eR1 = r1_valid && !eR0;
      gotW0 = w0_valid && w0_ready;
      gotW1 = w1_valid && w1_ready;
      gotR0 = r0_valid && r0_ready;
      gotR1 = r1_valid && r1_ready;
      checkOutput("w0_grant", gotW0, eW0);
      checkOutput("w1_grant", gotW1, eW1);
      checkOutput("r0_grant", gotR0, eR0);
      checkOutput("r1_grant", gotR1, eR1);
      checkOutput("wr_en", acc_wr_en, eW0 || eW1);
      if (eW0 || eW1) begin
         checkOutput("wr_addr", acc_wr_addr, eW1 ? w1_addr : w0_addr);
         checkOutput("wr_data", acc_wr_data, eW1 ? w1_data : w0_data);
      end
      checkOutput("rd_en", acc_rd_en, eR0 || eR1);
      if (eR0 || eR1) checkOutput("rd_addr", acc_rd_addr, eR1 ? r1_addr : r0_addr);
      rspPend = eR0 || eR1;
      rspId   = eR1;
      rspData = sb[bufSel][eR1 ? r1_addr : r0_addr];
      if (eW0) begin sb[bufSel][w0_addr] = w0_data; lastW = 1'b0; end
      if (eW1) begin sb[bufSel][w1_addr] = w1_data; lastW = 1'b1; end
      if (eR0) lastR = 1'b0;
      if (eR1) lastR = 1'b1;
      @(negedge clk);
   endtask

   // Counts cycles with every ready low, until some requester is accepted again
   task automatic waitAfterClear(output int idleCnt, output int clrCnt, output int selMoves);
      idleCnt = 0;
      clrCnt = 0;
      selMoves = 0;
      for (int c = 0; c < 1000; c++) begin
         #1;
         if (w0_ready || w1_ready || r0_ready || r1_ready || clr_ready || swp_ready) return;
         idleCnt++;
         if (acc_clear) clrCnt++;
         if (acc_buf_sel != bufSel) selMoves++;
         @(negedge clk);
      end
   endtask

   // Clear with W0 waiting: accept + start + 255 busy + completion seen + release = 259 stalled
   // cycles, of which the 257 middle ones (CLR_RUN) hold acc_clear high
   task automatic runClearWithW0(input logic [7:0] a, input logic [63:0] d);
      int idleCnt, clrCnt, selMoves;
      w0_valid = 1'b1; w0_addr = a; w0_data = d; clr_valid = 1'b1;
      #1;
      checkOutput("clr_accept", clr_ready, 1);
      checkOutput("clr_w0_held", w0_ready, 0);
      checkOutput("clr_no_wr", acc_wr_en, 0);
      @(negedge clk);
      clr_valid = 1'b0;
      waitAfterClear(idleCnt, clrCnt, selMoves);
      checkOutput("clr_stall_cycles", idleCnt + 1, 259);
      checkOutput("clr_high_cycles", clrCnt, 257);
      checkOutput("clr_sel_stable", selMoves, 0);
      for (int i = 0; i < 256; i++) sb[bufSel][i] = 64'd0;
      applyStimulus();
      w0_valid = 1'b0;
   endtask

   initial begin
      int cnt0, cnt1;
      int idleCnt, clrCnt, selMoves;
      rst_n = 1'b0;
      w0_valid = 0; w1_valid = 0; r0_valid = 0; r1_valid = 0;
      w0_addr = 0; w1_addr = 0; r0_addr = 0; r1_addr = 0;
      w0_data = 0; w1_data = 0; clr_valid = 0; swp_valid = 0;
      bufSel = 0; lastW = 1; lastR = 1; rspPend = 0; rspId = 0; rspData = 0;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 256; i++) sb[b][i] = 64'd0;

      #3;
      checkOutput("rst_idle", sched_idle, 1);
      checkOutput("rst_buf_sel", acc_buf_sel, 0);
      checkOutput("rst_clear", acc_clear, 0);
      checkOutput("rst_wr_en", acc_wr_en, 0);
      checkOutput("rst_rd_en", acc_rd_en, 0);
      checkOutput("rst_rsp_valid", rd_rsp_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] alternating writers");
      cnt0 = 0; cnt1 = 0;
      w0_valid = 1; w0_addr = 8'h10; w0_data = 64'h100;
      w1_valid = 1; w1_addr = 8'h20; w1_data = 64'h200;
      for (int i = 0; i < 6; i++) begin
         applyStimulus();
         if (gotW0) begin cnt0++; w0_data = w0_data + 64'd1; end
         if (gotW1) begin cnt1++; w1_data = w1_data + 64'd1; end
      end
      checkOutput("alt_w0_beats", cnt0, 3);
      checkOutput("alt_w1_beats", cnt1, 3);
      w0_valid = 0; w1_valid = 0;

      $display("[TB] write then read 0x05");
      w0_valid = 1; w0_addr = 8'h05; w0_data = 64'hDEAD_BEEF;
      applyStimulus();
      w0_valid = 0; r0_valid = 1; r0_addr = 8'h05;
      applyStimulus();
      r0_valid = 0;
      #1;
      checkOutput("deadbeef_data", rd_rsp_data, 64'hDEAD_BEEF);
      applyStimulus();

      $display("[TB] clear with writer waiting");
      runClearWithW0(8'h33, 64'h1234);
      r1_valid = 1; r1_addr = 8'h05;
      applyStimulus();
      r1_addr = 8'h20;
      applyStimulus();
      r1_valid = 0;
      applyStimulus();

      $display("[TB] random traffic");
      w0_valid = 1'($urandom_range(0, 1)); w0_addr = 8'($urandom_range(0, 15)); w0_data = {$urandom, $urandom};
      w1_valid = 1'($urandom_range(0, 1)); w1_addr = 8'($urandom_range(0, 15)); w1_data = {$urandom, $urandom};
      r0_valid = 1'($urandom_range(0, 1)); r0_addr = 8'($urandom_range(0, 15));
      r1_valid = 1'($urandom_range(0, 1)); r1_addr = 8'($urandom_range(0, 15));
      for (int n = 0; n < 300; n++) begin
         applyStimulus();
         if (gotW0 || !w0_valid) begin
            w0_valid = 1'($urandom_range(0, 1)); w0_addr = 8'($urandom_range(0, 15)); w0_data = {$urandom, $urandom};
         end
         if (gotW1 || !w1_valid) begin
            w1_valid = 1'($urandom_range(0, 1)); w1_addr = 8'($urandom_range(0, 15)); w1_data = {$urandom, $urandom};
         end
         if (gotR0 || !r0_valid) begin
            r0_valid = 1'($urandom_range(0, 1)); r0_addr = 8'($urandom_range(0, 15));
         end
         if (gotR1 || !r1_valid) begin
            r1_valid = 1'($urandom_range(0, 1)); r1_addr = 8'($urandom_range(0, 15));
         end
      end
      w0_valid = 0; w1_valid = 0; r0_valid = 0; r1_valid = 0;
      applyStimulus();

      $display("[TB] swap to buffer 1 and back");
      swp_valid = 1; w0_valid = 1; w0_addr = 8'h00; w0_data = 64'h1; r0_valid = 1; r0_addr = 8'h00;
      #1;
      checkOutput("swp_accept", swp_ready, 1);
      checkOutput("swp_w0_held", w0_ready, 0);
      checkOutput("swp_sel_before", acc_buf_sel, 0);
      @(negedge clk);
      swp_valid = 0; bufSel = 1'b1;
      #1;
      checkOutput("settle_sel", acc_buf_sel, 1);
      checkOutput("settle_w0_ready", w0_ready, 0);
      checkOutput("settle_r0_ready", r0_ready, 0);
      @(negedge clk);
      r0_valid = 0;
      applyStimulus();
      w0_valid = 0; r0_valid = 1;
      applyStimulus();
      r0_valid = 0; swp_valid = 1;
      #1;
      checkOutput("rsp_buf1_data", rd_rsp_data, 64'h1);
      checkOutput("swp_back_accept", swp_ready, 1);
      @(negedge clk);
      swp_valid = 0; bufSel = 1'b0; rspPend = 0;
      #1;
      checkOutput("swp_back_sel", acc_buf_sel, 0);
      @(negedge clk);
      r0_valid = 1;
      applyStimulus();
      r0_valid = 0;
      applyStimulus();

      $display("[TB] clear and swap together");
      clr_valid = 1; swp_valid = 1;
      #1;
      checkOutput("both_clr_ready", clr_ready, 1);
      checkOutput("both_swp_ready", swp_ready, 0);
      @(negedge clk);
      clr_valid = 0;
      waitAfterClear(idleCnt, clrCnt, selMoves);
      checkOutput("both_stall_cycles", idleCnt + 1, 259);
      checkOutput("both_clr_high", clrCnt, 257);
      checkOutput("both_sel_stable", selMoves, 0);
      checkOutput("both_swp_after", swp_ready, 1);
      for (int i = 0; i < 256; i++) sb[bufSel][i] = 64'd0;
      @(negedge clk);
      swp_valid = 0; bufSel = ~bufSel;
      #1;
      checkOutput("both_sel_toggled", acc_buf_sel, bufSel);
      checkOutput("both_settle_busy", sched_idle, 0);
      @(negedge clk);

      $display("[TB] reset in the middle of a clear");
      clr_valid = 1;
      @(negedge clk);
      clr_valid = 0;
      repeat (99) @(negedge clk);
      #1;
      checkOutput("midclr_active", acc_clear, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("midclr_rst_clear", acc_clear, 0);
      checkOutput("midclr_rst_idle", sched_idle, 1);
      checkOutput("midclr_rst_sel", acc_buf_sel, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bufSel = 0; lastW = 1; lastR = 1; rspPend = 0;
      runClearWithW0(8'h07, 64'hABCD);
      r0_valid = 1; r0_addr = 8'h05; r1_valid = 1; r1_addr = 8'h07;
      applyStimulus();
      applyStimulus();
      r0_valid = 0; r1_valid = 0;
      applyStimulus();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
